// File: rtl/modn_counter.sv
// rtl/modn_counter.sv - parametrised modulo-N up/down counter with clear, load and chaining tc
// q never leaves 0..MODULUS-1; tc is combinational so chained stages step on the same edge.
module modn_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10,
    parameter int INIT    = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ena,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             rollover,
    output logic             load_err
);

    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH-1:0] INIT_VAL = WIDTH'(INIT);

    if (MODULUS < 2) begin : g_bad_mod_low
        $error("modn_counter: MODULUS must be at least 2");
    end
    if (longint'(MODULUS) > (64'd1 << WIDTH)) begin : g_bad_mod_high
        $error("modn_counter: MODULUS exceeds 2**WIDTH");
    end
    if (INIT >= MODULUS) begin : g_bad_init
        $error("modn_counter: INIT must be below MODULUS");
    end

    logic [WIDTH-1:0] r_q;
    logic             r_rollover;
    logic             r_load_err;

    logic             w_at_max;
    logic             w_at_zero;
    logic             w_wrap;
    logic             w_load_over;
    logic [WIDTH-1:0] w_q_up;
    logic [WIDTH-1:0] w_q_dn;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_rollover_nxt;
    logic             w_load_err_nxt;

    assign w_at_max  = (r_q == MAX_VAL);
    assign w_at_zero = (r_q == '0);
    assign w_wrap    = ena & (up ? w_at_max : w_at_zero);

    // Compare one bit wider so MODULUS == 2**WIDTH is representable.
    assign w_load_over = ({1'b0, load_val} >= MOD_EXT);

    assign w_q_up = w_at_max  ? '0      : r_q + WIDTH'(1);
    assign w_q_dn = w_at_zero ? MAX_VAL : r_q - WIDTH'(1);

    always_comb begin
        w_q_nxt        = r_q;
        w_rollover_nxt = 1'b0;
        w_load_err_nxt = 1'b0;
        if (clr) begin
            w_q_nxt = '0;
        end else if (load) begin
            w_q_nxt        = w_load_over ? MAX_VAL : load_val;
            w_load_err_nxt = w_load_over;
        end else if (ena) begin
            w_q_nxt        = up ? w_q_up : w_q_dn;
            w_rollover_nxt = w_wrap;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_q        <= INIT_VAL;
            r_rollover <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_q        <= w_q_nxt;
            r_rollover <= w_rollover_nxt;
            r_load_err <= w_load_err_nxt;
        end
    end

    assign q        = r_q;
    assign tc       = w_wrap;
    assign rollover = r_rollover;
    assign load_err = r_load_err;

endmodule

// File: tb/tb_modn_counter.sv
// tb/tb_modn_counter.sv - randomized and directed bench for modn_counter against an arithmetic model
// Channels: 0=M10, 1=M8 (W3, full range), 2=chain low M10, 3=chain high M6, 4=M24 (W5, INIT 20).
module tb_modn_counter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;

    logic       a_ena = 0, a_clr = 0, a_load = 0, a_up = 0;
    logic [3:0] a_lv = 0;
    logic       c_ena = 0, c_clr = 0, c_load = 0, c_up = 0;
    logic [3:0] c_lv = 0;
    logic       b_ena = 0, b_clr = 0, b_load = 0, b_up = 0;
    logic [4:0] b_lv = 0;

    logic [3:0] a_q, lo_q, hi_q;
    logic [2:0] c8_q;
    logic [4:0] b_q;
    logic       a_tc, a_ro, a_le;
    logic       c8_tc, c8_ro, c8_le;
    logic       lo_tc, lo_ro, lo_le;
    logic       hi_tc, hi_ro, hi_le;
    logic       b_tc, b_ro, b_le;

    int n_vec = 0;
    int n_err = 0;

    int mod_t[5]  = '{10, 8, 10, 6, 24};
    int init_t[5] = '{0, 0, 0, 0, 20};
    int mq[5];
    int mr[5];
    int me[5];

    always #5 clk = ~clk;

    modn_counter #(.WIDTH(4), .MODULUS(10), .INIT(0)) u_a (
        .clk(clk), .reset_n(reset_n), .ena(a_ena), .clr(a_clr), .load(a_load),
        .load_val(a_lv), .up(a_up), .q(a_q), .tc(a_tc), .rollover(a_ro), .load_err(a_le));

    modn_counter #(.WIDTH(3), .MODULUS(8), .INIT(0)) u_c8 (
        .clk(clk), .reset_n(reset_n), .ena(a_ena), .clr(a_clr), .load(a_load),
        .load_val(a_lv[2:0]), .up(a_up), .q(c8_q), .tc(c8_tc), .rollover(c8_ro), .load_err(c8_le));

    modn_counter #(.WIDTH(4), .MODULUS(10), .INIT(0)) u_lo (
        .clk(clk), .reset_n(reset_n), .ena(c_ena), .clr(c_clr), .load(c_load),
        .load_val(c_lv), .up(c_up), .q(lo_q), .tc(lo_tc), .rollover(lo_ro), .load_err(lo_le));

    modn_counter #(.WIDTH(4), .MODULUS(6), .INIT(0)) u_hi (
        .clk(clk), .reset_n(reset_n), .ena(lo_tc), .clr(c_clr), .load(1'b0),
        .load_val(4'd0), .up(c_up), .q(hi_q), .tc(hi_tc), .rollover(hi_ro), .load_err(hi_le));

    modn_counter #(.WIDTH(5), .MODULUS(24), .INIT(20)) u_b (
        .clk(clk), .reset_n(reset_n), .ena(b_ena), .clr(b_clr), .load(b_load),
        .load_val(b_lv), .up(b_up), .q(b_q), .tc(b_tc), .rollover(b_ro), .load_err(b_le));

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_regs();
        int oq[5], orl[5], oe[5];
        oq  = '{int'(a_q), int'(c8_q), int'(lo_q), int'(hi_q), int'(b_q)};
        orl = '{int'(a_ro), int'(c8_ro), int'(lo_ro), int'(hi_ro), int'(b_ro)};
        oe  = '{int'(a_le), int'(c8_le), int'(lo_le), int'(hi_le), int'(b_le)};
        for (int ch = 0; ch < 5; ch++) begin
            check($sformatf("q[%0d]", ch), oq[ch], mq[ch]);
            check($sformatf("rollover[%0d]", ch), orl[ch], mr[ch]);
            check($sformatf("load_err[%0d]", ch), oe[ch], me[ch]);
        end
    endtask

    // One clock edge: check tc before the edge, advance the model, check registers after.
    task automatic cycle();
        int clr[5], ld[5], lv[5], en[5], upv[5], otc[5], etc_[5];
        int m, q;
        clr = '{int'(a_clr), int'(a_clr), int'(c_clr), int'(c_clr), int'(b_clr)};
        ld  = '{int'(a_load), int'(a_load), int'(c_load), 0, int'(b_load)};
        lv  = '{int'(a_lv), int'(a_lv) % 8, int'(c_lv), 0, int'(b_lv)};
        en  = '{int'(a_ena), int'(a_ena), int'(c_ena), 0, int'(b_ena)};
        upv = '{int'(a_up), int'(a_up), int'(c_up), int'(c_up), int'(b_up)};
        for (int ch = 0; ch < 5; ch++) begin
            if (ch == 3) en[3] = etc_[2];
            m = mod_t[ch];
            etc_[ch] = (en[ch] != 0) && (upv[ch] != 0 ? mq[ch] == m - 1 : mq[ch] == 0);
        end
        #1;
        otc = '{int'(a_tc), int'(c8_tc), int'(lo_tc), int'(hi_tc), int'(b_tc)};
        for (int ch = 0; ch < 5; ch++)
            check($sformatf("tc[%0d]", ch), otc[ch], etc_[ch]);
        for (int ch = 0; ch < 5; ch++) begin
            m = mod_t[ch];
            q = mq[ch];
            mr[ch] = 0;
            me[ch] = 0;
            if (clr[ch] != 0) begin
                mq[ch] = 0;
            end else if (ld[ch] != 0) begin
                if (lv[ch] < m) mq[ch] = lv[ch];
                else begin
                    mq[ch] = m - 1;
                    me[ch] = 1;
                end
            end else if (en[ch] != 0) begin
                if (upv[ch] != 0) begin
                    mq[ch] = (q + 1) % m;
                    mr[ch] = (q == m - 1);
                end else begin
                    mq[ch] = (q + m - 1) % m;
                    mr[ch] = (q == 0);
                end
            end
        end
        @(posedge clk);
        #1;
        check_regs();
    endtask

    task automatic idle_inputs();
        a_ena = 0; a_clr = 0; a_load = 0;
        c_ena = 0; c_clr = 0; c_load = 0;
        b_ena = 0; b_clr = 0; b_load = 0;
    endtask

    // Reset is asserted between edges and must take effect with no clock.
    task automatic do_reset();
        @(negedge clk);
        reset_n = 0;
        #1;
        for (int ch = 0; ch < 5; ch++) begin
            mq[ch] = init_t[ch];
            mr[ch] = 0;
            me[ch] = 0;
        end
        check_regs();
        idle_inputs();
        @(negedge clk);
        reset_n = 1;
    endtask

    initial begin
        do_reset();
        cycle();

        // Count M10 to 5 (and load B so it wraps to expose a pending pulse), then reset mid-count.
        a_ena = 1; a_up = 1;
        repeat (5) cycle();
        b_load = 1; b_lv = 5'd23; cycle();
        b_load = 0; b_ena = 1; b_up = 1; cycle();
        do_reset();

        // Eleven up-steps from 0 through the wrap.
        a_ena = 1; a_up = 1;
        repeat (11) cycle();

        // Clear, then count down through the 0 -> 9 wrap.
        a_clr = 1; cycle();
        a_clr = 0; a_up = 0;
        repeat (2) cycle();

        // Loads: in range, saturating, and clr overriding load.
        a_ena = 0; a_load = 1; a_lv = 4'd7; cycle();
        a_lv = 4'd12; cycle();
        a_clr = 1; cycle();
        a_clr = 0; a_load = 0; cycle();

        // Chain M10 -> M6 over a full 60-count lap plus one.
        c_clr = 1; cycle();
        c_clr = 0; c_ena = 1; c_up = 1;
        repeat (61) cycle();

        // M24: 23 -> 0 wrap, hold, count to 3, then reverse.
        b_load = 1; b_lv = 5'd23; cycle();
        b_load = 0; b_ena = 1; b_up = 1; cycle();
        b_ena = 0; repeat (3) cycle();
        b_ena = 1; repeat (3) cycle();
        b_up = 0; cycle();

        for (int i = 0; i < 2000; i++) begin
            a_ena  = ($urandom_range(0, 3) != 0);
            a_clr  = ($urandom_range(0, 19) == 0);
            a_load = ($urandom_range(0, 7) == 0);
            a_up   = 1'($urandom);
            a_lv   = 4'($urandom);
            c_ena  = ($urandom_range(0, 3) != 0);
            c_clr  = ($urandom_range(0, 39) == 0);
            c_load = ($urandom_range(0, 15) == 0);
            c_up   = ($urandom_range(0, 3) != 0);
            c_lv   = 4'($urandom);
            b_ena  = ($urandom_range(0, 3) != 0);
            b_clr  = ($urandom_range(0, 19) == 0);
            b_load = ($urandom_range(0, 7) == 0);
            b_up   = 1'($urandom);
            b_lv   = 5'($urandom);
            if ($urandom_range(0, 199) == 0) do_reset();
            else cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
